// File: rtl/flash_pkg.sv
// Shared types for the flash controller, its program sequencer and benches:
// command codes, completion codes and the sequencer state encoding.
package flash_pkg;

    typedef enum logic [7:0] {
        CMD_WR = 8'd0,
        CMD_RD = 8'd1,
        CMD_SE = 8'd2,
        CMD_BE = 8'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_VERIFY  = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_BADLEN  = 2'd3
    } err_e;

    typedef enum logic [3:0] {
        ST_IDLE, ST_CHK_LEN, ST_GAP,
        ST_SE_ISSUE, ST_SE_WAIT,
        ST_WR_ISSUE, ST_WR_WAIT,
        ST_RD_ISSUE, ST_RD_WAIT,
        ST_CMP, ST_FIN
    } seq_state_e;

    function automatic seq_state_e wait_of(seq_state_e s);
        case (s)
            ST_SE_ISSUE: return ST_SE_WAIT;
            ST_RD_ISSUE: return ST_RD_WAIT;
            default:     return ST_WR_WAIT;
        endcase
    endfunction

    // Step that follows a completed flash command.
    function automatic seq_state_e step_after(seq_state_e s);
        case (s)
            ST_SE_WAIT: return ST_WR_ISSUE;
            ST_WR_WAIT: return ST_RD_ISSUE;
            default:    return ST_CMP;
        endcase
    endfunction

    function automatic cmd_e cmd_of(seq_state_e s);
        case (s)
            ST_SE_ISSUE: return CMD_SE;
            ST_RD_ISSUE: return CMD_RD;
            default:     return CMD_WR;
        endcase
    endfunction

endpackage

// File: rtl/flash_verify_cmp.sv
// Masked read-back compare: only the low byte_num bytes take part.
module flash_verify_cmp #(
    parameter int C_MAX_BYTE_NUM = 2
) (
    input  logic [C_MAX_BYTE_NUM*8-1:0] wdata,
    input  logic [C_MAX_BYTE_NUM*8-1:0] rdata,
    input  logic [7:0]                  byte_num,
    output logic                        match
);

    logic [C_MAX_BYTE_NUM*8-1:0] mask;

    always_comb begin
        mask = '0;
        for (int i = 0; i < C_MAX_BYTE_NUM; i++) begin
            if (byte_num > 8'(i)) mask[i*8 +: 8] = 8'hFF;
        end
        match = ((wdata ^ rdata) & mask) == '0;
    end

endmodule

// File: rtl/flash_prog_seq.sv
// Program-region sequencer: optional erase, write, read-back and verify with
// retries, driving the flash SPI controller's command interface.
//
// state      | meaning
// IDLE       | ready for a request
// CHK_LEN    | validate byte count
// GAP        | enforced idle time after a FINISH before the next START
// SE_ISSUE   | sector erase pending, waiting for flash not busy
// SE_WAIT    | erase running
// WR_ISSUE   | write pending
// WR_WAIT    | write running
// RD_ISSUE   | read-back pending
// RD_WAIT    | read-back running, data captured on FINISH
// CMP        | masked compare of read vs write data
// FIN        | DONE pulse, results published
module flash_prog_seq
    import flash_pkg::*;
#(
    parameter int C_MAX_BYTE_NUM      = 2,
    parameter int C_MAX_RETRY         = 2,
    parameter int C_TIMEOUT_CLK_NUM   = 1000000,
    parameter int C_START_GAP_CLK_NUM = 4
) (
    input  logic                        SYS_CLK_I,
    input  logic                        SYS_RST_I,
    input  logic                        REQ_I,
    input  logic                        REQ_ERASE_I,
    input  logic [31:0]                 REQ_ADDR_I,
    input  logic [7:0]                  REQ_BYTE_NUM_I,
    input  logic [C_MAX_BYTE_NUM*8-1:0] REQ_DATA_I,
    output logic                        READY_O,
    output logic                        DONE_O,
    output logic [1:0]                  ERR_CODE_O,
    output logic [3:0]                  RETRY_CNT_O,
    output logic [7:0]                  CMD_O,
    output logic                        START_O,
    output logic [31:0]                 ADDR_O,
    output logic [7:0]                  BYTE_NUM_O,
    output logic [C_MAX_BYTE_NUM*8-1:0] PDATA_O,
    input  logic [C_MAX_BYTE_NUM*8-1:0] PDATA_I,
    input  logic                        BUSY_I,
    input  logic                        FINISH_I
);

    localparam int          W        = C_MAX_BYTE_NUM * 8;
    localparam logic [23:0] TMO_LOAD = 24'(C_TIMEOUT_CLK_NUM);
    localparam logic [7:0]  GAP_LOAD = 8'(C_START_GAP_CLK_NUM);

    seq_state_e  state, state_nxt, gap_ret;
    logic [31:0] req_addr;
    logic [7:0]  req_bn;
    logic        req_erase;
    logic [W-1:0] wdata, rdata;
    logic [3:0]  retry_cnt;
    logic [23:0] tmo_cnt;
    logic [7:0]  gap_cnt;
    logic        is_issue, is_wait, issue_nxt, tmo_hit, fire, finish_ok;
    logic        len_bad, retry_ok, match;
    err_e        err_nxt;

    flash_verify_cmp #(.C_MAX_BYTE_NUM(C_MAX_BYTE_NUM)) u_cmp (
        .wdata    (wdata),
        .rdata    (rdata),
        .byte_num (req_bn),
        .match    (match)
    );

    always_ff @(posedge SYS_CLK_I) begin
        if (SYS_RST_I) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (REQ_I) state_nxt = ST_CHK_LEN;
            ST_CHK_LEN: begin
                if (len_bad)        state_nxt = ST_FIN;
                else if (req_erase) state_nxt = ST_SE_ISSUE;
                else                state_nxt = ST_WR_ISSUE;
            end
            ST_SE_ISSUE, ST_WR_ISSUE, ST_RD_ISSUE: begin
                if (tmo_hit)      state_nxt = ST_FIN;
                else if (!BUSY_I) state_nxt = wait_of(state);
            end
            ST_SE_WAIT, ST_WR_WAIT, ST_RD_WAIT: begin
                if (finish_ok) state_nxt = (GAP_LOAD == 8'd0) ? step_after(state) : ST_GAP;
                else if (tmo_hit) state_nxt = ST_FIN;
            end
            ST_GAP:     if (gap_cnt == 8'd1) state_nxt = gap_ret;
            ST_CMP: begin
                if (match)         state_nxt = ST_FIN;
                else if (retry_ok) state_nxt = req_erase ? ST_SE_ISSUE : ST_WR_ISSUE;
                else               state_nxt = ST_FIN;
            end
            ST_FIN:     state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        READY_O   = (state == ST_IDLE);
        DONE_O    = (state == ST_FIN);
        is_issue  = state inside {ST_SE_ISSUE, ST_WR_ISSUE, ST_RD_ISSUE};
        is_wait   = state inside {ST_SE_WAIT, ST_WR_WAIT, ST_RD_WAIT};
        issue_nxt = state_nxt inside {ST_SE_ISSUE, ST_WR_ISSUE, ST_RD_ISSUE};
        tmo_hit   = (is_issue || is_wait) && (tmo_cnt == 24'd1);
        fire      = is_issue && !tmo_hit && !BUSY_I;
        // A FINISH coinciding with our own START belongs to an earlier command.
        finish_ok = is_wait && FINISH_I && !START_O;
        len_bad   = (req_bn == 8'd0) || (req_bn > 8'(C_MAX_BYTE_NUM));
        retry_ok  = retry_cnt < 4'(C_MAX_RETRY);
        case (state)
            ST_CHK_LEN: err_nxt = ERR_BADLEN;
            ST_CMP:     err_nxt = match ? ERR_OK : ERR_VERIFY;
            default:    err_nxt = ERR_TIMEOUT;
        endcase
    end

    always_ff @(posedge SYS_CLK_I) begin
        if (SYS_RST_I) begin
            req_addr    <= '0;
            req_bn      <= '0;
            req_erase   <= 1'b0;
            wdata       <= '0;
            rdata       <= '0;
            retry_cnt   <= '0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
            gap_ret     <= ST_IDLE;
            START_O     <= 1'b0;
            CMD_O       <= '0;
            ADDR_O      <= '0;
            BYTE_NUM_O  <= '0;
            PDATA_O     <= '0;
            ERR_CODE_O  <= '0;
            RETRY_CNT_O <= '0;
        end else begin
            START_O <= fire;
            if (READY_O && REQ_I) begin
                req_addr   <= REQ_ADDR_I;
                req_bn     <= REQ_BYTE_NUM_I;
                req_erase  <= REQ_ERASE_I;
                wdata      <= REQ_DATA_I;
                retry_cnt  <= '0;
                ERR_CODE_O <= ERR_OK;
            end
            // Command fields settle on ISSUE entry, a cycle ahead of START.
            if (issue_nxt) begin
                CMD_O      <= cmd_of(state_nxt);
                ADDR_O     <= req_addr;
                BYTE_NUM_O <= req_bn;
                PDATA_O    <= wdata;
            end
            if (issue_nxt && (state_nxt != state)) tmo_cnt <= TMO_LOAD;
            else if (is_issue || is_wait)          tmo_cnt <= tmo_cnt - 24'd1;
            if ((state_nxt == ST_GAP) && (state != ST_GAP)) begin
                gap_cnt <= GAP_LOAD;
                gap_ret <= step_after(state);
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
            if ((state == ST_RD_WAIT) && finish_ok) rdata <= PDATA_I;
            if ((state == ST_CMP) && !match && retry_ok) retry_cnt <= retry_cnt + 4'd1;
            if (state_nxt == ST_FIN) begin
                ERR_CODE_O  <= err_nxt;
                RETRY_CNT_O <= retry_cnt;
            end
        end
    end

endmodule

// File: tb/tb_flash_prog_seq.sv
// Bench for flash_prog_seq: behavioural flash responder plus a pass-level
// reference model of the erase/write/read/verify/retry sequence.
module tb_flash_prog_seq;
    import flash_pkg::*;

    localparam int MAXR = 2;
    localparam int GAP  = 4;

    logic        clk = 1'b0;
    logic        SYS_RST_I, REQ_I, REQ_ERASE_I;
    logic [31:0] REQ_ADDR_I;
    logic [7:0]  REQ_BYTE_NUM_I;
    logic [15:0] REQ_DATA_I;
    logic        READY_O, DONE_O, START_O;
    logic [1:0]  ERR_CODE_O;
    logic [3:0]  RETRY_CNT_O;
    logic [7:0]  CMD_O, BYTE_NUM_O;
    logic [31:0] ADDR_O;
    logic [15:0] PDATA_O, PDATA_I;
    logic        BUSY_I, FINISH_I;

    flash_prog_seq #(
        .C_MAX_BYTE_NUM(2), .C_MAX_RETRY(MAXR),
        .C_TIMEOUT_CLK_NUM(100), .C_START_GAP_CLK_NUM(GAP)
    ) dut (
        .SYS_CLK_I(clk), .SYS_RST_I(SYS_RST_I), .REQ_I(REQ_I),
        .REQ_ERASE_I(REQ_ERASE_I), .REQ_ADDR_I(REQ_ADDR_I),
        .REQ_BYTE_NUM_I(REQ_BYTE_NUM_I), .REQ_DATA_I(REQ_DATA_I),
        .READY_O(READY_O), .DONE_O(DONE_O), .ERR_CODE_O(ERR_CODE_O),
        .RETRY_CNT_O(RETRY_CNT_O), .CMD_O(CMD_O), .START_O(START_O),
        .ADDR_O(ADDR_O), .BYTE_NUM_O(BYTE_NUM_O), .PDATA_O(PDATA_O),
        .PDATA_I(PDATA_I), .BUSY_I(BUSY_I), .FINISH_I(FINISH_I)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0, passes = 0, fails = 0;
    logic [3:0]  cmd_log[$];
    logic [15:0] rd_q[$];
    int start_cnt, field_err, gap_err, first_start_cyc, last_start_cyc, fin_cyc;
    bit hang = 0, busy_hold = 0;
    logic [31:0] exp_addr;
    logic [7:0]  exp_bn;
    logic [15:0] exp_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flash responder: logs every START, answers after a random latency.
    initial begin
        int lat;
        bit active;
        active = 0; lat = 0;
        BUSY_I = 0; FINISH_I = 0; PDATA_I = '0;
        forever begin
            @(negedge clk);
            FINISH_I = 0;
            if (SYS_RST_I) active = 0;
            else if (active) begin
                lat--;
                if (lat == 0) begin
                    active = 0;
                    if (!hang) begin FINISH_I = 1; fin_cyc = cyc; end
                end
            end else if (START_O) begin
                cmd_log.push_back(CMD_O[3:0]);
                start_cnt++;
                if (start_cnt == 1) first_start_cyc = cyc;
                last_start_cyc = cyc;
                if (ADDR_O !== exp_addr || BYTE_NUM_O !== exp_bn || PDATA_O !== exp_data) field_err++;
                if (cyc - fin_cyc - 1 < GAP) gap_err++;
                if (CMD_O == 8'(CMD_RD)) PDATA_I = (rd_q.size() > 0) ? rd_q.pop_front() : 16'h0;
                active = 1;
                lat = $urandom_range(2, 8);
            end
            BUSY_I = active | busy_hold;
        end
    end

    // Pass-level model: each pass issues [SE] WR RD and verifies the low bytes.
    function automatic void ref_model(input bit er, input logic [7:0] bn, input logic [15:0] wd,
                                      input logic [15:0] r0, r1, r2,
                                      output logic [63:0] seq, output int n, output int err, output int rty);
        logic [15:0] rd[3];
        logic [31:0] m;
        rd = '{r0, r1, r2};
        seq = 0; n = 0; rty = 0;
        if (bn < 1 || bn > 2) begin err = 3; return; end
        m = (32'd1 << (8 * bn)) - 1;
        for (int p = 0; p <= MAXR; p++) begin
            if (er) begin seq = (seq << 4) | 64'(CMD_SE); n++; end
            seq = (seq << 4) | 64'(CMD_WR); n++;
            seq = (seq << 4) | 64'(CMD_RD); n++;
            if (((32'(rd[p]) ^ 32'(wd)) & m) == 0) begin err = 0; rty = p; return; end
        end
        err = 1; rty = MAXR;
    endfunction

    task automatic run_req(input string tag, input bit er, input logic [31:0] addr, input logic [7:0] bn,
                           input logic [15:0] wd, input logic [15:0] r0, r1, r2,
                           input logic [63:0] eseq, input int en, input int eerr, input int erty,
                           output int lat, output int done_cyc);
        logic [63:0] seq;
        bit seen;
        cmd_log.delete(); rd_q.delete();
        rd_q.push_back(r0); rd_q.push_back(r1); rd_q.push_back(r2);
        start_cnt = 0; field_err = 0; gap_err = 0; fin_cyc = -1000;
        exp_addr = addr; exp_bn = bn; exp_data = wd;
        chk({tag, ".ready_before"}, 64'(READY_O), 1);
        REQ_ERASE_I = er; REQ_ADDR_I = addr; REQ_BYTE_NUM_I = bn; REQ_DATA_I = wd; REQ_I = 1;
        @(posedge clk); #1;
        REQ_I = 0;
        chk({tag, ".ready_busy"}, 64'(READY_O), 0);
        seen = 0; lat = 0; done_cyc = 0;
        for (int k = 0; k < 3000; k++) begin
            if (DONE_O) begin seen = 1; lat = k; done_cyc = cyc; break; end
            // Requests and input churn while busy must have no effect.
            REQ_I = !READY_O && ($urandom_range(0, 7) == 0);
            REQ_ADDR_I = $urandom;
            REQ_DATA_I = 16'($urandom);
            @(posedge clk); #1;
        end
        REQ_I = 0;
        chk({tag, ".done_seen"}, 64'(seen), 1);
        chk({tag, ".err_code"}, 64'(ERR_CODE_O), 64'(eerr));
        chk({tag, ".retry_cnt"}, 64'(RETRY_CNT_O), 64'(erty));
        seq = 0;
        foreach (cmd_log[i]) seq = (seq << 4) | 64'(cmd_log[i]);
        chk({tag, ".start_count"}, 64'(start_cnt), 64'(en));
        chk({tag, ".cmd_seq"}, seq, eseq);
        chk({tag, ".fields"}, 64'(field_err), 0);
        chk({tag, ".gap"}, 64'(gap_err), 0);
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, 64'(DONE_O), 0);
        chk({tag, ".ready_after"}, 64'(READY_O), 1);
    endtask

    initial begin
        logic [63:0] eseq;
        int en, eerr, erty, lat, dcyc, dcnt, rel_cyc;
        bit er, seen;
        logic [7:0] bn;
        logic [15:0] wd, r[3];
        logic [31:0] addr;

        SYS_RST_I = 1; REQ_I = 0; REQ_ERASE_I = 0; REQ_ADDR_I = 0; REQ_BYTE_NUM_I = 0; REQ_DATA_I = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", 64'(READY_O), 1);
        chk("rst.done", 64'(DONE_O), 0);
        chk("rst.start", 64'(START_O), 0);
        chk("rst.err", 64'(ERR_CODE_O), 0);
        chk("rst.retry", 64'(RETRY_CNT_O), 0);
        chk("rst.cmd_addr_bn_pdata", {CMD_O, ADDR_O, BYTE_NUM_O, PDATA_O}, 0);
        SYS_RST_I = 0;
        @(posedge clk); #1;

        ref_model(1, 2, 16'hAABB, 16'hAABB, 16'hAABB, 16'hAABB, eseq, en, eerr, erty);
        run_req("erase_echo", 1, 32'hFF0000, 2, 16'hAABB, 16'hAABB, 16'hAABB, 16'hAABB, eseq, en, eerr, erty, lat, dcyc);

        ref_model(0, 2, 16'hAABB, 16'hAAB0, 16'hAABB, 16'hAABB, eseq, en, eerr, erty);
        run_req("one_retry", 0, 32'hFF0000, 2, 16'hAABB, 16'hAAB0, 16'hAABB, 16'hAABB, eseq, en, eerr, erty, lat, dcyc);

        ref_model(0, 1, 16'hAABB, 16'h12BB, 16'h0, 16'h0, eseq, en, eerr, erty);
        run_req("mask_low_byte", 0, 32'h100, 1, 16'hAABB, 16'h12BB, 16'h0, 16'h0, eseq, en, eerr, erty, lat, dcyc);

        ref_model(0, 2, 16'hAABB, 16'h0, 16'h0, 16'h0, eseq, en, eerr, erty);
        run_req("verify_fail", 0, 32'h200, 2, 16'hAABB, 16'h0, 16'h0, 16'h0, eseq, en, eerr, erty, lat, dcyc);

        ref_model(0, 0, 16'h1234, 16'h0, 16'h0, 16'h0, eseq, en, eerr, erty);
        run_req("len_zero", 0, 32'h300, 0, 16'h1234, 16'h0, 16'h0, 16'h0, eseq, en, eerr, erty, lat, dcyc);
        chk("len_zero.latency_le2", 64'(lat <= 2), 1);
        ref_model(1, 3, 16'h1234, 16'h0, 16'h0, 16'h0, eseq, en, eerr, erty);
        run_req("len_three", 1, 32'h300, 3, 16'h1234, 16'h0, 16'h0, 16'h0, eseq, en, eerr, erty, lat, dcyc);

        hang = 1;
        run_req("timeout", 0, 32'h400, 2, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 64'(CMD_WR), 1, 2, 0, lat, dcyc);
        chk("timeout.window", 64'((dcyc - last_start_cyc >= 95) && (dcyc - last_start_cyc <= 105)), 1);
        hang = 0;

        busy_hold = 1;
        @(posedge clk); #1;
        rel_cyc = 0;
        ref_model(0, 2, 16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h3C3C, eseq, en, eerr, erty);
        fork
            begin
                repeat (50) @(posedge clk);
                chk("busy.no_start_while_busy", 64'(start_cnt), 0);
                rel_cyc = cyc;
                busy_hold = 0;
            end
            run_req("busy", 0, 32'h500, 2, 16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h3C3C, eseq, en, eerr, erty, lat, dcyc);
        join
        chk("busy.start_after_release", 64'(first_start_cyc >= rel_cyc), 1);

        for (int t = 0; t < 12; t++) begin
            er = 1'($urandom_range(0, 1));
            bn = 8'($urandom_range(0, 5));
            if (bn > 3) bn = 2;
            wd = 16'($urandom);
            addr = $urandom;
            for (int p = 0; p < 3; p++)
                r[p] = ($urandom_range(0, 1) == 1) ? wd : (wd ^ 16'($urandom_range(1, 65535)));
            ref_model(er, bn, wd, r[0], r[1], r[2], eseq, en, eerr, erty);
            run_req($sformatf("rand%0d", t), er, addr, bn, wd, r[0], r[1], r[2], eseq, en, eerr, erty, lat, dcyc);
        end

        // Reset while the read-back is in flight.
        cmd_log.delete(); rd_q.delete(); rd_q.push_back(16'h7777);
        start_cnt = 0; fin_cyc = -1000;
        exp_addr = 32'h600; exp_bn = 2; exp_data = 16'h7777;
        REQ_ERASE_I = 0; REQ_ADDR_I = 32'h600; REQ_BYTE_NUM_I = 2; REQ_DATA_I = 16'h7777; REQ_I = 1;
        @(posedge clk); #1;
        REQ_I = 0;
        seen = 0;
        for (int k = 0; k < 500; k++) begin
            if (START_O && CMD_O == 8'(CMD_RD)) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        chk("rst_mid.rd_started", 64'(seen), 1);
        SYS_RST_I = 1;
        @(posedge clk); #1;
        chk("rst_mid.ready", 64'(READY_O), 1);
        chk("rst_mid.start", 64'(START_O), 0);
        SYS_RST_I = 0;
        dcnt = 0;
        for (int k = 0; k < 150; k++) begin
            if (DONE_O) dcnt++;
            @(posedge clk); #1;
        end
        chk("rst_mid.no_done", 64'(dcnt), 0);
        chk("rst_mid.ready_hold", 64'(READY_O), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/flash_prog_seq.md
Name: flash_prog_seq

Overview:
- Sequencer placed directly upstream of the `flash` SPI controller; it drives that controller's command/start/addr/byte-count/data inputs.
- Turns one "program region" request into a command sequence: optional sector erase (SE), write (WR), read-back (RD), compare.
- Retries on verify mismatch up to a limit.
- Reports completion with a one-cycle DONE pulse plus an error code.

Parameters:
- C_MAX_BYTE_NUM, 2, max bytes per request; data bus width is C_MAX_BYTE_NUM*8.
- C_MAX_RETRY, 2, extra erase/write/verify passes after the first failed verify (0..15).
- C_TIMEOUT_CLK_NUM, 1000000, SYS_CLK cycles allowed per wait state before timeout (<= 2^24-1).
- C_START_GAP_CLK_NUM, 4, idle SYS_CLK cycles between FINISH_I and the next START_O (<= 255).

Ports:
- SYS_CLK_I  in  1  system clock
- SYS_RST_I  in  1  synchronous, active-high reset
- REQ_I  in  1  request strobe, sampled only while READY_O=1
- REQ_ERASE_I  in  1  1 = issue SE before WR
- REQ_ADDR_I  in  32  flash address
- REQ_BYTE_NUM_I  in  8  byte count, valid range 1..C_MAX_BYTE_NUM
- REQ_DATA_I  in  C_MAX_BYTE_NUM*8  write data
- READY_O  out  1  idle, request can be accepted
- DONE_O  out  1  one-cycle completion pulse
- ERR_CODE_O  out  2  0 ok, 1 verify fail, 2 timeout, 3 bad length; valid with DONE_O, held until next accept
- RETRY_CNT_O  out  4  retries used in last request
- CMD_O  out  8  to flash CMD_I (WR=0, RD=1, SE=2, BE=3)
- START_O  out  1  to flash START_I, one-cycle pulse
- ADDR_O  out  32  to flash ADDR_I
- BYTE_NUM_O  out  8  to flash BYTE_NUM_I
- PDATA_O  out  C_MAX_BYTE_NUM*8  to flash PDATA_I
- PDATA_I  in  C_MAX_BYTE_NUM*8  from flash PDATA_O (read data)
- BUSY_I  in  1  from flash BUSY_O
- FINISH_I  in  1  from flash FINISH_O, one-cycle pulse

Behaviour:
- Reset values: READY_O=1 (state IDLE); DONE_O=0, START_O=0, ERR_CODE_O=0, RETRY_CNT_O=0, CMD_O=0, ADDR_O=0, BYTE_NUM_O=0, PDATA_O=0.
- States: IDLE, CHK_LEN, GAP, SE_ISSUE, SE_WAIT, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, CMP, FIN.
- IDLE, REQ_I=1: latch addr/data/byte_num/erase flag; clear retry count and ERR_CODE_O; go CHK_LEN. READY_O=0 from next cycle.
- CHK_LEN:
  - BYTE_NUM 0 or >C_MAX_BYTE_NUM -> FIN with code 3; no START_O ever issued.
  - Otherwise -> SE_ISSUE if erase flag is set, else WR_ISSUE.
- *_ISSUE:
  - Drive CMD_O/ADDR_O/BYTE_NUM_O/PDATA_O (registered, stable from one cycle before START_O until FINISH_I).
  - When BUSY_I=0, pulse START_O one cycle and go *_WAIT.
  - While BUSY_I=1, hold without pulsing.
  - Timeout counter runs here too.
- *_WAIT:
  - FINISH_I=1 -> GAP, then the next step (SE->WR, WR->RD, RD->CMP).
  - RD_WAIT captures PDATA_I on the FINISH_I cycle.
  - FINISH_I in the same cycle as START_O is ignored.
- Timeout: counter clears on entry to each ISSUE state. Reaching C_TIMEOUT_CLK_NUM -> FIN with code 2; no further START_O.
- GAP: count C_START_GAP_CLK_NUM cycles. 0 means go directly to the next state.
- CMP:
  - Compare only the low BYTE_NUM*8 bits of read vs write data; upper bits are masked.
  - Match -> FIN, code 0.
  - Mismatch and retry<C_MAX_RETRY -> retry+1; go to SE_ISSUE (erase flag set) or WR_ISSUE.
  - Otherwise -> FIN, code 1.
- FIN: DONE_O=1 for one cycle; RETRY_CNT_O updated; -> IDLE. READY_O=1 from the cycle after DONE_O.
- REQ_I outside IDLE is ignored (not queued).
- Reset mid-operation: any state -> IDLE next edge. START_O low, partial results discarded. The flash controller shares SYS_RST_I.
- Exactly one START_O per ISSUE state visit.

Decomposition:
- Shared package flash_pkg:
  - CMD codes WR/RD/SE/BE.
  - Error codes OK/VERIFY/TIMEOUT/BADLEN.
  - Sequencer state enum.
  - Shared by `flash`, this block, and benches.
- One sub-module: flash_verify_cmp. Combinational masked compare of (wdata, rdata, byte_num) -> match. Reusable by a future read-scrub block.

Test Plan:
- REQ addr 0xFF0000, data 0xAABB, byte_num 2, erase=1; flash model echoes 0xAABB -> START_O with CMD 2, then 0, then 1; DONE_O with code 0, RETRY_CNT_O 0.
- Same request, erase=0, model returns 0xAAB0 first, then 0xAABB -> CMD sequence 0,1,0,1; code 0, RETRY_CNT_O 1.
- byte_num 1, data 0xAABB, read returns 0x12BB -> match on low byte only; code 0.
- Model always returns 0x0000, C_MAX_RETRY=2 -> 3 write/read passes; code 1, RETRY_CNT_O 2.
- Model never pulses FINISH_I after WR, C_TIMEOUT_CLK_NUM=100 -> DONE_O ~100 cycles after START_O, code 2; no RD issued. byte_num 0 -> DONE within 3 cycles, code 3, zero START_O.
- BUSY_I held high 50 cycles in WR_ISSUE -> START_O only after BUSY_I drops. SYS_RST_I pulsed during RD_WAIT -> READY_O=1 next cycle, no DONE_O.
